// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction prefetch queue.
// master = prefetch queue, slave = memory/decode/redirect environment.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [XLEN-1:0]   imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [XLEN-1:0]   instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: 1-cycle memory, DEPTH-entry FIFO to decode, redirect flush.
// Latency request->instr_valid is 2 cycles; IPQ_BYPASS_EN adds an empty-queue bypass making it 1.
module instr_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    instr_prefetch_queue_if.master       bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]   dat;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_q, out_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              accept, bypass, push, pop, fifo_pop, req;
    logic [CW:0]       occupancy;
    entry_t            head;

    always_comb begin
        accept = bus.imem_valid & out_q & ~bus.redirect_valid;
`ifdef IPQ_BYPASS_EN
        bypass = accept & (count_q == '0);
`else
        bypass = 1'b0;
`endif
        head = mem_q[rd_ptr_q];

        bus.instr_valid = ~bus.redirect_valid & ((count_q != '0) | bypass);
        bus.instr_data  = '0;
        bus.instr_pc    = '0;
        if (bus.instr_valid) begin
            if (count_q != '0) begin
                bus.instr_data = head.dat;
                bus.instr_pc   = head.pc;
            end else begin
                bus.instr_data = bus.imem_rdata;
                bus.instr_pc   = out_addr_q;
            end
        end

        pop      = bus.instr_valid & bus.instr_ready;
        fifo_pop = pop & (count_q != '0);
        // A bypassed word that decode takes immediately never touches storage.
        push     = accept & ~(bypass & pop);

        // Slots committed after this edge: stored + in flight - leaving now.
        occupancy = {1'b0, count_q} + (CW+1)'(out_q) - (CW+1)'(pop);
        req       = ~reset & ~bus.redirect_valid & (occupancy < (CW+1)'(DEPTH));

        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_q;

        fetch_pc_d = fetch_pc_q;
        out_addr_d = out_addr_q;
        out_d      = req;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            out_d      = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                out_addr_d = fetch_pc_q;
            end
            if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
            if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_addr_q <= RESET_PC;
            out_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_addr_q <= out_addr_d;
            out_q      <= out_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{dat: bus.imem_rdata, pc: out_addr_q};
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 1-cycle memory model and a PC scoreboard.
module tb_instr_prefetch_queue;
    logic clk = 1'b0;
    logic reset;
    logic mem_vld = 1'b0;
    logic [31:0] mem_dat = '0;
    logic stale;
    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.ADDR_W(32), .XLEN(32)) bus ();

    instr_prefetch_queue #(.ADDR_W(32), .XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory answers every request one cycle later with 0xA000_0000 + word index.
    always @(posedge clk) begin
        mem_vld <= bus.imem_req;
        mem_dat <= 32'hA000_0000 + (bus.imem_addr >> 2);
    end
    assign bus.imem_valid = mem_vld | stale;
    assign bus.imem_rdata = stale ? 32'hDEAD_BEEF : mem_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each issued address is expected back in order unless flushed.
    always @(negedge clk) begin
        if (bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", bus.instr_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", bus.instr_pc, e);
                chk("sb_data", bus.instr_data, 32'hA000_0000 + (e >> 2));
            end
        end
        if (reset || bus.redirect_valid) exp_q.delete();
        if (bus.imem_req) begin
            exp_q.push_back(bus.imem_addr);
            req_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    initial begin
        int pops;
        int r0;
        logic [31:0] lat1_exp;
`ifdef IPQ_BYPASS_EN
        lat1_exp = 32'd1;
`else
        lat1_exp = 32'd0;
`endif
        reset = 1'b1;
        stale = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_data", bus.instr_data, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);

        // Streaming with decode always ready.
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_req0", {31'b0, bus.imem_req}, 32'd1);
        chk("t1_addr0", bus.imem_addr, 32'h0);
        chk("t1_valid_n0", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        chk("t1_addr1", bus.imem_addr, 32'h4);
        chk("t1_valid_n1", {31'b0, bus.instr_valid}, lat1_exp);
        @(negedge clk);
        chk("t1_valid_n2", {31'b0, bus.instr_valid}, 32'd1);
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.instr_valid) pops++;
        end
        chk("t1_no_gaps", pops, 32'd10);

        // Backpressure: exactly DEPTH fetches, then drain and resume.
        step();
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        step();
        reset = 1'b0;
        r0 = req_cnt;
        repeat (12) @(negedge clk);
        chk("t2_req_count", req_cnt - r0, 32'd4);
        chk("t2_req_idle", {31'b0, bus.imem_req}, 32'd0);
        chk("t2_head_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("t2_head_pc", bus.instr_pc, 32'h0);
        step();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_resume_req", {31'b0, bus.imem_req}, 32'd1);
        chk("t2_resume_addr", bus.imem_addr, 32'h10);
        repeat (8) @(negedge clk);

        // Redirect with 3 queued entries and one fetch in flight.
        step();
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("t3_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("t3_pre_req", {31'b0, bus.imem_req}, 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        bus.instr_ready    = 1'b1;
        @(negedge clk);
        chk("t3_redir_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("t3_redir_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        wait_valid("t3_wait", 10);
        chk("t3_first_pc", bus.instr_pc, 32'h100);
        repeat (4) @(negedge clk);

        // Misaligned redirect target and back-to-back redirects.
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_align_addr", bus.imem_addr, 32'h100);
        chk("t4_align_req", {31'b0, bus.imem_req}, 32'd1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid("t4_wait", 10);
        chk("t4_last_wins", bus.instr_pc, 32'h300);
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-stream and a stale response after release.
        step();
        reset = 1'b1;
        #2;
        chk("t5_req", {31'b0, bus.imem_req}, 32'd0);
        chk("t5_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("t5_data", bus.instr_data, 32'h0);
        chk("t5_pc", bus.instr_pc, 32'h0);
        chk("t5_addr", bus.imem_addr, 32'h0);
        step();
        reset = 1'b0;
        stale = 1'b1;
        @(negedge clk);
        chk("t5_rel_addr", bus.imem_addr, 32'h0);
        chk("t5_rel_req", {31'b0, bus.imem_req}, 32'd1);
        step();
        stale = 1'b0;
        wait_valid("t5_wait", 10);
        chk("t5_first_pc", bus.instr_pc, 32'h0);
        chk("t5_first_data", bus.instr_data, 32'hA000_0000);
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Parametrised instruction fetch front-end for the SoC CPU.
- Issues sequential word fetches to program memory with fixed 1-cycle read latency.
- Buffers returned words in a DEPTH-entry FIFO and hands them, with their PC, to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with full flush and discard of any in-flight fetch.

Parameters:
- ADDR_W, 32, fetch address width; PC wraps modulo 2^ADDR_W.
- XLEN, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  word-aligned fetch address; equals the internal fetch PC.
- imem_valid  in  1  response strobe; memory asserts it exactly 1 cycle after imem_req.
- imem_rdata  in  XLEN  response word, qualified by imem_valid.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 00.
- instr_valid  out  1  head entry available.
- instr_ready  in  1  decode accepts the head entry.
- instr_data  out  XLEN  head instruction; 0 when instr_valid=0.
- instr_pc  out  ADDR_W  PC of the head instruction; 0 when instr_valid=0.

Behaviour:
- Reset, asynchronous and immediate:
  - fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, outstanding=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - FIFO storage is not reset.
- State: fetch_pc, outstanding flag plus its address, FIFO pointers, and count (width clog2(DEPTH)+1).
- Pop: pop = instr_valid & instr_ready.
- Issue rule: imem_req=1 iff !redirect_valid and (count + outstanding - pop) < DEPTH. On issue:
  - fetch_pc += 4, wrapping;
  - outstanding=1 with the issued address latched.
- Response handling:
  - Accepted only if imem_valid=1, outstanding=1 and no redirect this cycle.
  - An accepted response writes {rdata, latched addr} at wr_ptr.
  - imem_valid with outstanding=0 is ignored.
- Ordering and throughput:
  - Strict FIFO order; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot) and when empty (no bypass unless the option below is enabled).
- Latency without the option:
  - request at cycle N, response at N+1, instr_valid at N+2.
  - Steady-state throughput is 1 instruction/cycle.
- Backpressure: with instr_ready=0, exactly DEPTH fetches are issued, then imem_req stays 0. instr_valid and the head entry hold until popped.
- Redirect, highest priority:
  - In the redirect cycle: instr_valid forced 0 combinationally, so no pop occurs; imem_req=0; any response arriving is discarded.
  - At the next edge: count=0, pointers reset, outstanding=0, fetch_pc={redirect_pc[ADDR_W-1:2],2'b00}.
  - The first request is issued the following cycle.
- Back-to-back redirects: the last one wins; each flushes again.
- Reset mid-operation: the in-flight response is lost. After release, fetch restarts at RESET_PC on the first edge with reset=0.
- fetch_pc wraps from 2^ADDR_W-4 to 0 with no error.

Optional Feature:
- Macro: IPQ_BYPASS_EN.
- Defined: when count=0 and an accepted response arrives, instr_valid/instr_data/instr_pc are driven combinationally from imem_rdata and the latched address in that same cycle.
  - If instr_ready=1, the word is consumed and not written.
  - Otherwise it is written normally.
  - Request-to-instr_valid latency becomes 1.
- Undefined: no combinational path from imem_rdata to outputs; latency 2 as above.

Test Plan:
1. DEPTH=4, RESET_PC=0, mem[k]=0xA000_0000+k, instr_ready=1, release reset → imem_addr 0,4,8,...; instr_valid from cycle 2; instr_pc/instr_data 0/0xA0000000, 4/0xA0000001, ... one per cycle, no gaps.
2. instr_ready=0 after reset → exactly 4 requests (0x0,0x4,0x8,0xC), then imem_req=0 indefinitely. Raise ready → drains 0x0..0xC in order, then fetches resume at 0x10 with no bubble beyond one cycle.
3. Queue holding 3 entries plus 1 outstanding; redirect_valid=1, redirect_pc=0x100 → instr_valid=0 that cycle. Next delivered instr_pc=0x100; no word from the old stream ever appears.
4. redirect_pc=0x102 → next imem_addr=0x100. Two consecutive redirects 0x200 then 0x300 → first delivered instr_pc=0x300.
5. Reset asserted mid-stream between edges → all outputs 0 immediately. After release → imem_addr=RESET_PC; a stale imem_valid pulse is ignored.
6. IPQ_BYPASS_EN defined, empty queue, ready=1 → instr_valid in the same cycle as imem_valid. Undefined → one cycle later. Same data sequence in both cases.
